// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern link (transmitter and recognizer).
package pattern_pkg;

  localparam int SYNC_LEN = 4;
  localparam logic [SYNC_LEN-1:0] SYNC_PATTERN_DEF = 4'b1101;

  // Binary state encoding; PARITY is only reachable in parity builds.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } tx_state_t;

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load, shift-left payload register exposing its MSB.
// PATTERN_TX_PARITY_EN adds an even-parity latch captured at load.
module pattern_shift_reg
  import pattern_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
`ifdef PATTERN_TX_PARITY_EN
  output logic             parity,
`endif
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk) begin
    if (!reset)     shreg <= '0;
    else if (load)  shreg <= data_in;
    else if (shift) shreg <= {shreg[WIDTH-2:0], 1'b0};
  end

  assign msb = shreg[WIDTH-1];

`ifdef PATTERN_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset)    parity <= 1'b0;
    else if (load) parity <= ^data_in;
  end
`endif

endmodule

// File: rtl/pattern_transmitter_moore.sv
// Moore serial frame transmitter: sync pattern then payload MSB first, idle low.
// Optional trailing even-parity bit when PATTERN_TX_PARITY_EN is defined.
module pattern_transmitter_moore
  import pattern_pkg::*;
#(
  parameter int                  WIDTH        = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             string_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] SYNC_END  = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] DATA_END  = CW'(WIDTH - 1);
  localparam logic [1:0]    SYNC_LAST = 2'(SYNC_LEN - 1);

  tx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_nxt;
  logic          load, shift;
  logic          msb;
`ifdef PATTERN_TX_PARITY_EN
  logic          parity;
`endif

  pattern_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .shift   (shift),
    .data_in (data_in),
`ifdef PATTERN_TX_PARITY_EN
    .parity  (parity),
`endif
    .msb     (msb)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      frame_done <= done_nxt;
    end
  end

  // Only load/shift depend on inputs; every output below decodes registered state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          load      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = SYNC;
        end
      end
      SYNC: begin
        if (cnt == SYNC_END) begin
          cnt_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        shift = 1'b1;
        if (cnt == DATA_END) begin
          cnt_nxt = '0;
`ifdef PATTERN_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = IDLE;
          done_nxt  = 1'b1;
`endif
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
`ifdef PATTERN_TX_PARITY_EN
      PARITY: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    string_out = 1'b0;
    case (state)
      SYNC:   string_out = SYNC_PATTERN[SYNC_LAST - cnt[1:0]];
      DATA:   string_out = msb;
`ifdef PATTERN_TX_PARITY_EN
      PARITY: string_out = parity;
`endif
      default: string_out = 1'b0;
    endcase
  end

  assign data_ready = (state == IDLE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_pattern_transmitter_moore.sv
// Scoreboard bench: each accepted word pushes its expected per-cycle output stream.
module tb_pattern_transmitter_moore;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready, string_out, busy, frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  string tname;

  // {string_out, data_ready, busy, frame_done}
  logic [3:0] exp_q[$];
  localparam logic [3:0] IDLE_EXP = 4'b0100;

  pattern_transmitter_moore #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .string_out (string_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic push_frame(input logic [W-1:0] d);
    logic [3:0] sp;
    sp = 4'b1101;
    for (int i = 3; i >= 0; i--)   exp_q.push_back({sp[i], 1'b0, 1'b1, 1'b0});
    for (int i = W-1; i >= 0; i--) exp_q.push_back({d[i], 1'b0, 1'b1, 1'b0});
`ifdef PATTERN_TX_PARITY_EN
    exp_q.push_back({^d, 1'b0, 1'b1, 1'b0});
`endif
    exp_q.push_back(4'b0101);
  endtask

  // Check this cycle's outputs, then drive inputs for the coming edge.
  task automatic cycle(input logic v, input logic [W-1:0] d);
    logic [3:0] exp, obs;
    @(negedge clk);
    cyc++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_EXP;
    obs = {string_out, data_ready, busy, frame_done};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d {out,ready,busy,done} got=%b exp=%b", tname, cyc, obs, exp);
    end
    data_valid = v;
    data_in    = d;
    if (v && exp[2] && reset) push_frame(d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      cycle(1'b0, '0);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain timeout left=%0d exp=0", tname, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    tname = "reset";
    reset = 1'b0; data_valid = 1'b0; data_in = '0;
    repeat (3) cycle(1'b0, '0);
    reset = 1'b1;
    repeat (5) cycle(1'b0, '0);
  endtask

  task automatic test_single();
    tname = "single_a5";
    cycle(1'b1, 8'hA5);
    cycle(1'b0, 8'h00);
    drain();
    repeat (2) cycle(1'b0, '0);
  endtask

  task automatic test_back_to_back();
    tname = "back_to_back";
    cycle(1'b1, 8'hFF);
    repeat (W + 8) cycle(1'b1, 8'h00);
    drain();
    repeat (2) cycle(1'b0, '0);
  endtask

  task automatic test_valid_busy();
    tname = "valid_busy";
    cycle(1'b1, 8'h96);
    repeat (4) cycle(1'b0, 8'h00);
    repeat (W + 2) cycle(1'b1, 8'h3C);
    cycle(1'b0, 8'h00);
    drain();
    repeat (2) cycle(1'b0, '0);
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid";
    cycle(1'b1, 8'hC3);
    repeat (8) cycle(1'b0, 8'h00);
    reset = 1'b0;
    exp_q.delete();
    cycle(1'b0, 8'h00);
    reset = 1'b1;
    repeat (W + 4) cycle(1'b0, '0);
  endtask

  task automatic test_parity_word();
    tname = "word_07";
    cycle(1'b1, 8'h07);
    cycle(1'b0, 8'h00);
    drain();
    cycle(1'b0, '0);
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    tname = "random";
    for (int k = 0; k < 6; k++) begin
      w = W'($urandom);
      cycle(1'b1, w);
      cycle(1'b0, '0);
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_valid_busy();
    test_reset_mid();
    test_parity_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_transmitter_moore.md
Name: pattern_transmitter_moore

Overview:
Serial frame transmitter, the sending end of the serial pattern-recognition link. It accepts a parallel word through a valid/ready handshake and emits it one bit per clock on string_out. Each frame is a fixed 4-bit sync pattern (1101) followed by the payload, MSB first. The downstream Moore recognizer locks onto the sync pattern; the line idles low.

Parameters:
WIDTH, 8, payload width in bits (legal range 2..32)
SYNC_PATTERN, 4'b1101, sync bits, sent MSB first

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on the clk rising edge)
data_in  input  WIDTH  payload word
data_valid  input  1  data_in is valid
data_ready  output  1  block can accept a word (high only in IDLE)
string_out  output  1  serial bit stream
busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-cycle pulse after the last bit of a frame

Behaviour:
- Moore FSM; all outputs decode from registered state, counter and shift register only. No combinational path from inputs to outputs.
- States: IDLE, SYNC, DATA, plus PARITY when PARITY_EN is defined.
- Reset (reset==0 at a clk edge): state=IDLE, bit counter=0, shift register=0, frame_done=0. Outputs after reset: string_out=0, data_ready=1, busy=0.
- Reset mid-frame aborts the frame immediately; no frame_done pulse.
- IDLE:
  - string_out=0, data_ready=1.
  - On data_valid && data_ready: load data_in into the shift register, clear the counter, go to SYNC.
- SYNC:
  - string_out=SYNC_PATTERN[3-cnt]; cnt counts 0..3.
  - At cnt==3, clear cnt and go to DATA.
- DATA:
  - string_out=shreg[WIDTH-1]; shift left one position per cycle; cnt counts 0..WIDTH-1.
  - At cnt==WIDTH-1, go to IDLE (or to PARITY when enabled).
- Latency:
  - First sync bit appears on string_out in the cycle after the handshake.
  - A frame is 4+WIDTH bit-cycles (+1 with PARITY_EN).
- frame_done is registered and high for exactly the first IDLE cycle after a completed frame.
- Back-to-back frames: data_ready is high in that same IDLE cycle, so a new word can be accepted there. This guarantees a minimum of one idle 0 bit between frames, which resets the recognizer.
- data_valid while busy is ignored (data_ready=0). The source holds the word until the handshake.
- data_in is sampled only at the handshake; later changes have no effect on the frame in flight.
- Counter width is $clog2(WIDTH+1). The counter never wraps past its terminal value.
- Payload may contain 1101, which can cause false detection at the receiver. That is a system-level concern; the block applies no stuffing.

Optional Feature:
Macro PATTERN_TX_PARITY_EN.
- Defined:
  - After the last DATA bit, the block enters PARITY for one cycle.
  - string_out = even parity (XOR) of the loaded word, latched at the handshake.
  - Frame length is 5+WIDTH bit-cycles.
- Undefined:
  - The PARITY state and parity register are absent.
  - DATA goes directly to IDLE; frame length is 4+WIDTH.

Decomposition:
- Package pattern_pkg holds:
  - state encoding localparams (IDLE, SYNC, DATA, PARITY; binary encoding)
  - SYNC_PATTERN default and SYNC_LEN=4, shared with the recognizer.
- One natural sub-module, pattern_shift_reg. It holds:
  - the WIDTH-bit parallel-load, shift-left register exposing its MSB
  - the optional parity latch.
- FSM and counter stay in the top module.

Test Plan:
1. Reset and idle: hold reset=0 for 3 cycles, then release; data_valid=0 for 5 cycles -> string_out=0, data_ready=1, busy=0, frame_done=0 throughout.
2. Single frame, WIDTH=8, data_in=8'hA5 -> string_out from the cycle after the handshake is 1,1,0,1,1,0,1,0,0,1,0,1. busy=1 for those 12 cycles; frame_done pulses on cycle 13.
3. Back-to-back: 8'hFF then 8'h00 with data_valid held high -> 12 bits, one idle 0 (frame_done=1, second handshake in that cycle), then 1,1,0,1,0×8.
4. Valid during busy: assert data_valid with 8'h3C at cycle 5 of a frame -> ignored until the next IDLE cycle; frame 1 bits are unchanged.
5. Reset mid-frame: drive reset=0 at DATA bit 3 -> the next cycle shows string_out=0, data_ready=1, and no frame_done pulse.
6. With PATTERN_TX_PARITY_EN, data_in=8'h07 -> 1,1,0,1,0,0,0,0,0,1,1,1, then parity bit 1 (13 bits); frame_done pulses on cycle 14.
